// File: rtl/rv32_imem_bank_pkg.sv
// rv32_pkg: shared sizes, types and loader states for the rv32 instruction memory bank
package rv32_pkg;
    localparam int RV32_IMEM_DEPTH = 8192;
    localparam int RV32_IMEM_AW = $clog2(RV32_IMEM_DEPTH);
    typedef logic [RV32_IMEM_AW-1:0] rv32_imem_addr_t;
    typedef logic [3:0] rv32_imem_be_t;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} rv32_imem_ld_state_e;
endpackage

// File: rtl/rv32_imem_bank_if.sv
// rv32_imem_bank_if: fetch read port, host write port and streaming load port of the imem bank
interface rv32_imem_bank_if #(
    parameter int DW = 32,
    parameter int AW = rv32_pkg::RV32_IMEM_AW
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW/8-1:0] wr_be;
    logic [DW-1:0] wr_data;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic [AW:0]   ld_count;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data,
        output ld_start, ld_base, ld_count, ld_valid, ld_data,
        input  rd_data, rd_valid, ld_ready, ld_busy, ld_done
    );
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data,
        input  ld_start, ld_base, ld_count, ld_valid, ld_data,
        output rd_data, rd_valid, ld_ready, ld_busy, ld_done
    );
endinterface

// File: rtl/rv32_imem_bank_loader.sv
// rv32_imem_loader: boot-time streaming loader; owns the RAM write port while in LOAD
module rv32_imem_loader
    import rv32_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = RV32_IMEM_AW
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_count,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_busy,
    output logic          ld_done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);
    rv32_imem_ld_state_e state, state_nxt;
    logic [AW-1:0] ptr;
    logic [AW:0]   rem;
    logic          take;
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && ld_start) begin
                ptr <= ld_base;
                rem <= ld_count;
            end else if (take) begin
                ptr <= ptr + AW'(1);
                rem <= rem - (AW+1)'(1);
            end
        end
    end
    always_comb begin
        take      = state == LOAD && ld_valid;
        state_nxt = (state == IDLE && ld_start) ? (ld_count != '0 ? LOAD : DONE) :
                    (take && rem == (AW+1)'(1)) ? DONE :
                    (state == DONE)             ? IDLE : state;
        ld_ready  = state == LOAD;
        ld_busy   = state == LOAD;
        ld_done   = state == DONE;
        we        = take;
        waddr     = ptr;
        wdata     = ld_data;
    end
    // pointer wraps naturally at AW bits, so more than DEPTH words would overwrite the start
    a_count_legal: assert property (@(posedge clock) disable iff (!rst_n)
        (state == IDLE && ld_start) |-> ld_count <= (AW+1)'(1 << AW));
endmodule

// File: rtl/rv32_imem_bank.sv
// rv32_imem_bank: simple-dual-port instruction RAM with byte-lane writes, collision bypass,
// 1- or 2-cycle read pipe and an integrated boot loader
module rv32_imem_bank
    import rv32_pkg::*;
#(
    parameter int DW       = 32,
    parameter int DEPTH    = RV32_IMEM_DEPTH,
    parameter int RD_LAT   = 1,
    parameter bit WR_FIRST = 1'b0
) (
    input logic clock,
    input logic rst_n,
    rv32_imem_bank_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DW / 8;
    logic [DW-1:0] mem [DEPTH];
    logic          ld_we, we, v1;
    logic [AW-1:0] ld_waddr, waddr;
    logic [DW-1:0] ld_wdata, wdata, rd_word, d1;
    logic [NB-1:0] wbe;
    rv32_imem_loader #(.DW(DW), .AW(AW)) u_loader (
        .clock    (clock),
        .rst_n    (rst_n),
        .ld_start (bus.ld_start),
        .ld_base  (bus.ld_base),
        .ld_count (bus.ld_count),
        .ld_valid (bus.ld_valid),
        .ld_data  (bus.ld_data),
        .ld_ready (bus.ld_ready),
        .ld_busy  (bus.ld_busy),
        .ld_done  (bus.ld_done),
        .we       (ld_we),
        .waddr    (ld_waddr),
        .wdata    (ld_wdata)
    );
    always_comb begin
        we      = bus.ld_busy ? ld_we    : bus.wr_en;
        waddr   = bus.ld_busy ? ld_waddr : bus.wr_addr;
        wdata   = bus.ld_busy ? ld_wdata : bus.wr_data;
        wbe     = bus.ld_busy ? '1       : bus.wr_be;
        rd_word = mem[bus.rd_addr];
        for (int i = 0; i < NB; i++)
            if (WR_FIRST && we && wbe[i] && waddr == bus.rd_addr)
                rd_word[8*i +: 8] = wdata[8*i +: 8];
    end
    always_ff @(posedge clock) begin
        for (int i = 0; i < NB; i++)
            if (we && wbe[i])
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= bus.rd_en;
            if (bus.rd_en)
                d1 <= rd_word;
        end
    end
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          v2;
            logic [DW-1:0] d2;
            always_ff @(posedge clock) begin
                if (!rst_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1)
                        d2 <= d1;
                end
            end
            assign bus.rd_valid = v2;
            assign bus.rd_data  = d2;
        end else begin : g_lat1
            assign bus.rd_valid = v1;
            assign bus.rd_data  = d1;
        end
    endgenerate
endmodule

// File: tb/tb_rv32_imem_bank.sv
// tb_rv32_imem_bank: directed checks on a 16-word, 2-cycle, old-data bank (a)
// and a 64-word, 1-cycle, new-data bank (b)
module tb_rv32_imem_bank;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clock = ~clock;

    rv32_imem_bank_if #(.DW(32), .AW(4)) a ();
    rv32_imem_bank_if #(.DW(32), .AW(6)) b ();

    rv32_imem_bank #(.DW(32), .DEPTH(16), .RD_LAT(2), .WR_FIRST(1'b0)) dut_a (
        .clock(clock), .rst_n(rst_n), .bus(a));
    rv32_imem_bank #(.DW(32), .DEPTH(64), .RD_LAT(1), .WR_FIRST(1'b1)) dut_b (
        .clock(clock), .rst_n(rst_n), .bus(b));

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        a.rd_en = 0; a.rd_addr = '0; a.wr_en = 0; a.wr_addr = '0; a.wr_be = '0; a.wr_data = '0;
        a.ld_start = 0; a.ld_base = '0; a.ld_count = '0; a.ld_valid = 0; a.ld_data = '0;
        b.rd_en = 0; b.rd_addr = '0; b.wr_en = 0; b.wr_addr = '0; b.wr_be = '0; b.wr_data = '0;
        b.ld_start = 0; b.ld_base = '0; b.ld_count = '0; b.ld_valid = 0; b.ld_data = '0;
    endtask

    task automatic wr_a(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
        a.wr_en = 1; a.wr_addr = ad; a.wr_data = d; a.wr_be = be;
        cyc();
        a.wr_en = 0;
    endtask

    task automatic wr_b(input logic [5:0] ad, input logic [31:0] d, input logic [3:0] be);
        b.wr_en = 1; b.wr_addr = ad; b.wr_data = d; b.wr_be = be;
        cyc();
        b.wr_en = 0;
    endtask

    task automatic rd_a(input logic [3:0] ad, output logic [31:0] d);
        a.rd_en = 1; a.rd_addr = ad;
        cyc();
        a.rd_en = 0;
        cyc();
        d = a.rd_data;
    endtask

    task automatic rd_b(input logic [5:0] ad, output logic [31:0] d);
        b.rd_en = 1; b.rd_addr = ad;
        cyc();
        b.rd_en = 0;
        d = b.rd_data;
    endtask

    task automatic test_reset();
        wr_a(4'd3, 32'h1234_5678, 4'hF);
        a.rd_en = 1; a.rd_addr = 4'd3;
        a.ld_start = 1; a.ld_base = 4'd8; a.ld_count = 5'd5;
        cyc();
        a.ld_start = 0;
        cyc();
        n_cmp++; if (a.rd_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: got %b want 1", a.rd_valid); end
        n_cmp++; if (a.rd_data !== 32'h1234_5678) begin n_bad++; $display("FAIL pre_reset_data: got %h want 12345678", a.rd_data); end
        n_cmp++; if (a.ld_busy !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy: got %b want 1", a.ld_busy); end
        rst_n = 0;
        cyc();
        n_cmp++; if (a.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_a: got %b want 0", a.rd_valid); end
        n_cmp++; if (a.rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_data_a: got %h want 0", a.rd_data); end
        n_cmp++; if (a.ld_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", a.ld_busy); end
        n_cmp++; if (a.ld_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", a.ld_done); end
        n_cmp++; if (a.ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", a.ld_ready); end
        n_cmp++; if (b.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid_b: got %b want 0", b.rd_valid); end
        n_cmp++; if (b.rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_data_b: got %h want 0", b.rd_data); end
        cyc();
        a.rd_en = 0;
        rst_n = 1;
        cyc();
    endtask

    task automatic test_byte_write();
        logic [31:0] d;
        wr_b(6'h10, 32'hDEAD_BEEF, 4'hF);
        wr_b(6'h10, 32'h0000_5500, 4'b0010);
        rd_b(6'h10, d);
        n_cmp++; if (b.rd_valid !== 1'b1) begin n_bad++; $display("FAIL bw_valid_b: got %b want 1", b.rd_valid); end
        n_cmp++; if (d !== 32'hDEAD_55EF) begin n_bad++; $display("FAIL bw_data_b: got %h want dead55ef", d); end
        wr_b(6'h10, 32'hFFFF_FFFF, 4'h0);
        rd_b(6'h10, d);
        n_cmp++; if (d !== 32'hDEAD_55EF) begin n_bad++; $display("FAIL bw_be0_noop: got %h want dead55ef", d); end
        wr_a(4'd5, 32'hDEAD_BEEF, 4'hF);
        wr_a(4'd5, 32'h0000_5500, 4'b0010);
        a.rd_en = 1; a.rd_addr = 4'd5;
        cyc();
        a.rd_en = 0;
        n_cmp++; if (a.rd_valid !== 1'b0) begin n_bad++; $display("FAIL bw_lat2_early: got %b want 0", a.rd_valid); end
        cyc();
        n_cmp++; if (a.rd_valid !== 1'b1) begin n_bad++; $display("FAIL bw_lat2_valid: got %b want 1", a.rd_valid); end
        n_cmp++; if (a.rd_data !== 32'hDEAD_55EF) begin n_bad++; $display("FAIL bw_data_a: got %h want dead55ef", a.rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int k = 0; k < 4; k++) wr_a(4'(k), 32'hA000_0000 + k, 4'hF);
        for (int k = 0; k < 8; k++) begin
            a.rd_en = (k < 4); a.rd_addr = 4'(k);
            cyc();
            exp = 32'hA000_0000 + ((k >= 1 && k <= 4) ? k - 1 : 3);
            n_cmp++;
            if (a.rd_valid !== (k >= 1 && k <= 4)) begin
                n_bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, a.rd_valid, (k >= 1 && k <= 4));
            end
            if (k >= 1) begin
                n_cmp++;
                if (a.rd_data !== exp) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, a.rd_data, exp); end
            end
        end
        a.rd_en = 0;
    endtask

    task automatic test_collision();
        logic [31:0] d;
        wr_a(4'd2, 32'hAAAA_AAAA, 4'hF);
        a.wr_en = 1; a.wr_addr = 4'd2; a.wr_data = 32'h1111_1111; a.wr_be = 4'hF;
        a.rd_en = 1; a.rd_addr = 4'd2;
        cyc();
        a.wr_en = 0; a.rd_en = 0;
        cyc();
        n_cmp++; if (a.rd_data !== 32'hAAAA_AAAA) begin n_bad++; $display("FAIL coll_old: got %h want aaaaaaaa", a.rd_data); end
        rd_a(4'd2, d);
        n_cmp++; if (d !== 32'h1111_1111) begin n_bad++; $display("FAIL coll_old_after: got %h want 11111111", d); end
        wr_b(6'h20, 32'hAAAA_AAAA, 4'hF);
        b.wr_en = 1; b.wr_addr = 6'h20; b.wr_data = 32'h1111_1111; b.wr_be = 4'hF;
        b.rd_en = 1; b.rd_addr = 6'h20;
        cyc();
        n_cmp++; if (b.rd_data !== 32'h1111_1111) begin n_bad++; $display("FAIL coll_new: got %h want 11111111", b.rd_data); end
        b.wr_data = 32'h0000_00FF; b.wr_be = 4'b0001;
        cyc();
        b.wr_en = 0; b.rd_en = 0;
        n_cmp++; if (b.rd_data !== 32'h1111_11FF) begin n_bad++; $display("FAIL coll_merge: got %h want 111111ff", b.rd_data); end
        rd_b(6'h20, d);
        n_cmp++; if (d !== 32'h1111_11FF) begin n_bad++; $display("FAIL coll_merge_after: got %h want 111111ff", d); end
    endtask

    task automatic test_load_wrap();
        logic [31:0] w [4];
        logic [31:0] d;
        logic [3:0]  ad [4];
        logic rdy, v;
        int n, pulses;
        w = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
        ad = '{4'd14, 4'd15, 4'd0, 4'd1};
        a.ld_start = 1; a.ld_base = 4'd14; a.ld_count = 5'd4;
        cyc();
        a.ld_start = 0;
        n_cmp++; if (a.ld_busy !== 1'b1 || a.ld_ready !== 1'b1) begin
            n_bad++; $display("FAIL ld_enter: got busy=%b ready=%b want 1 1", a.ld_busy, a.ld_ready);
        end
        n = 0; pulses = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            rdy = a.ld_ready; v = i[0];
            a.ld_valid = v; a.ld_data = w[n];
            a.wr_en = 1; a.wr_addr = 4'd15; a.wr_data = 32'hFFFF_FFFF; a.wr_be = 4'hF;
            cyc();
            if (rdy && v) n++;
            if (a.ld_done) pulses++;
        end
        a.wr_en = 0; a.ld_valid = 0;
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL ld_timeout: got %0d words want 4", n); end
        n_cmp++; if (a.ld_busy !== 1'b0 || a.ld_ready !== 1'b0) begin
            n_bad++; $display("FAIL ld_exit: got busy=%b ready=%b want 0 0", a.ld_busy, a.ld_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (a.ld_done) pulses++;
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ld_done_pulses: got %0d want 1", pulses); end
        for (int k = 0; k < 4; k++) begin
            rd_a(ad[k], d);
            n_cmp++; if (d !== w[k]) begin n_bad++; $display("FAIL ld_word@%0d: got %h want %h", ad[k], d, w[k]); end
        end
        rd_a(4'd2, d);
        n_cmp++; if (d !== 32'h1111_1111) begin n_bad++; $display("FAIL ld_overrun: got %h want 11111111", d); end
    endtask

    task automatic test_edge_loads();
        logic [31:0] d;
        a.ld_base = 4'd5; a.ld_count = 5'd0; a.ld_valid = 1; a.ld_data = 32'hBAD0_BAD0;
        a.ld_start = 1;
        cyc();
        a.ld_start = 0;
        n_cmp++; if (a.ld_done !== 1'b1 || a.ld_busy !== 1'b0) begin
            n_bad++; $display("FAIL ld0_done: got done=%b busy=%b want 1 0", a.ld_done, a.ld_busy);
        end
        cyc();
        a.ld_valid = 0;
        n_cmp++; if (a.ld_done !== 1'b0) begin n_bad++; $display("FAIL ld0_pulse: got %b want 0", a.ld_done); end
        rd_a(4'd5, d);
        n_cmp++; if (d !== 32'hDEAD_55EF) begin n_bad++; $display("FAIL ld0_nowrite: got %h want dead55ef", d); end
        wr_a(4'd10, 32'h1010_1010, 4'hF);
        a.ld_base = 4'd8; a.ld_count = 5'd5; a.ld_start = 1;
        cyc();
        a.ld_start = 0; a.ld_valid = 1; a.ld_data = 32'h5EED_0000;
        cyc();
        a.ld_data = 32'h5EED_0001;
        cyc();
        a.ld_valid = 0; a.ld_data = 32'h5EED_0002;
        rst_n = 0;
        cyc();
        n_cmp++; if (a.ld_busy !== 1'b0 || a.ld_done !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_load: got busy=%b done=%b want 0 0", a.ld_busy, a.ld_done);
        end
        rst_n = 1;
        cyc();
        n_cmp++; if (a.ld_done !== 1'b0 || a.ld_busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_after: got done=%b busy=%b want 0 0", a.ld_done, a.ld_busy);
        end
        rd_a(4'd8, d);
        n_cmp++; if (d !== 32'h5EED_0000) begin n_bad++; $display("FAIL rst_keep0: got %h want 5eed0000", d); end
        rd_a(4'd9, d);
        n_cmp++; if (d !== 32'h5EED_0001) begin n_bad++; $display("FAIL rst_keep1: got %h want 5eed0001", d); end
        rd_a(4'd10, d);
        n_cmp++; if (d !== 32'h1010_1010) begin n_bad++; $display("FAIL rst_untouched: got %h want 10101010", d); end
    endtask

    initial begin
        idle_all();
        cyc();
        cyc();
        rst_n = 1;
        cyc();
        test_reset();
        test_byte_write();
        test_back_to_back();
        test_collision();
        test_load_wrap();
        test_edge_loads();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
